cla16_adder: RTL and testbench



---
 rtl/cla16_adder.sv | 66 ++++++
 tb/tb_cla16_adder.sv | 130 +++++++++++++
 2 files changed

// File: rtl/cla16_adder.sv
// Registered 16-bit adder built from four 4-bit carry-lookahead groups and a
// second-level lookahead unit; {cout, sum} is captured one cycle after a/b.
module cla16_adder (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [15:0] sum,
  output logic        cout
);

  logic        cin;
  logic [15:0] g, p, c;
  logic [3:0]  gg, gp;
  logic [4:0]  gc;
  logic [15:0] sum_d, sum_q;
  logic        cout_d, cout_q;

  // Kept as a named net so the full lookahead equations stay uniform.
  assign cin = 1'b0;
  assign g   = a & b;
  assign p   = a ^ b;

  for (genvar j = 0; j < 4; j++) begin : g_group
    localparam int unsigned B = 4 * j;

    assign gg[j] = g[B+3] | (p[B+3] & g[B+2]) | (p[B+3] & p[B+2] & g[B+1])
                 | (p[B+3] & p[B+2] & p[B+1] & g[B]);
    assign gp[j] = p[B+3] & p[B+2] & p[B+1] & p[B];

    assign c[B]   = gc[j];
    assign c[B+1] = g[B] | (p[B] & gc[j]);
    assign c[B+2] = g[B+1] | (p[B+1] & g[B]) | (p[B+1] & p[B] & gc[j]);
    assign c[B+3] = g[B+2] | (p[B+2] & g[B+1]) | (p[B+2] & p[B+1] & g[B])
                  | (p[B+2] & p[B+1] & p[B] & gc[j]);
  end

  // Second-level lookahead: every group carry-in is a flat sum of products.
  assign gc[0] = cin;
  assign gc[1] = gg[0] | (gp[0] & cin);
  assign gc[2] = gg[1] | (gp[1] & gg[0]) | (gp[1] & gp[0] & cin);
  assign gc[3] = gg[2] | (gp[2] & gg[1]) | (gp[2] & gp[1] & gg[0])
               | (gp[2] & gp[1] & gp[0] & cin);
  assign gc[4] = gg[3] | (gp[3] & gg[2]) | (gp[3] & gp[2] & gg[1])
               | (gp[3] & gp[2] & gp[1] & gg[0])
               | (gp[3] & gp[2] & gp[1] & gp[0] & cin);

  always_comb begin
    sum_d  = p ^ c;
    cout_d = gc[4];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q  <= 16'h0000;
      cout_q <= 1'b0;
    end else begin
      sum_q  <= sum_d;
      cout_q <= cout_d;
    end
  end

  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_cla16_adder.sv
// Self-checking bench for cla16_adder: directed table, reset sequences and
// random back-to-back adds checked through an expected-result queue.
module tb_cla16_adder;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] a, b, sum;
  logic        cout;

  always #5 clk = ~clk;

  cla16_adder dut (
    .clk  (clk),
    .rst  (rst),
    .a    (a),
    .b    (b),
    .sum  (sum),
    .cout (cout)
  );

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [16:0] e;
  } vec_t;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [16:0] exp_q[$];
  string       tag_q[$];

  task automatic drive(input logic r, input logic [15:0] va, input logic [15:0] vb,
                       input logic [16:0] e, input string tag);
    @(negedge clk);
    rst = r;
    a   = va;
    b   = vb;
    exp_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  task automatic check_out();
    logic [16:0] e;
    string       t;
    @(posedge clk);
    #1;
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_bad++;
      $display("FAIL scoreboard: no expected entry, got {cout,sum}=%h", {cout, sum});
    end else begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      if ({cout, sum} !== e) begin
        n_bad++;
        $display("FAIL %s: got {cout,sum}=%h want %h", t, {cout, sum}, e);
      end
    end
  endtask

  task automatic step(input logic r, input logic [15:0] va, input logic [15:0] vb,
                      input logic [16:0] e, input string tag);
    drive(r, va, vb, e, tag);
    check_out();
  endtask

  initial begin
    vec_t        vecs[9];
    logic [15:0] ra, rb;
    logic [16:0] held;

    vecs[0] = '{16'hA0A0, 16'hA0A0, 17'h14140};
    vecs[1] = '{16'h58F4, 16'hF4F4, 17'h14DE8};
    vecs[2] = '{16'h0F3D, 16'h0F0F, 17'h01E4C};
    vecs[3] = '{16'hC8CA, 16'hC8CA, 17'h19194};
    vecs[4] = '{16'hFFFF, 16'h0001, 17'h10000};
    vecs[5] = '{16'h7FFF, 16'h0001, 17'h08000};
    vecs[6] = '{16'h0FFF, 16'h0001, 17'h01000};
    vecs[7] = '{16'h0000, 16'h0000, 17'h00000};
    vecs[8] = '{16'h1234, 16'h0000, 17'h01234};

    rst = 1'b1;
    a   = 16'hFFFF;
    b   = 16'hFFFF;

    // Reset dominates even with all-ones operands, then the first load.
    step(1'b1, 16'hFFFF, 16'hFFFF, 17'h00000, "reset_cycle0");
    step(1'b1, 16'hFFFF, 16'hFFFF, 17'h00000, "reset_cycle1");
    step(1'b0, 16'hFFFF, 16'hFFFF, 17'h1FFFE, "first_load");

    for (int i = 0; i < 9; i++) begin
      step(1'b0, vecs[i].a, vecs[i].b, vecs[i].e, $sformatf("vec%0d", i));
    end

    // Operand changes between edges must not reach the outputs.
    step(1'b0, 16'h1111, 16'h2222, 17'h03333, "pre_hold");
    held = 17'h03333;
    a    = 16'hFFFF;
    b    = 16'hFFFF;
    #2;
    n_cmp++;
    if ({cout, sum} !== held) begin
      n_bad++;
      $display("FAIL hold_between_edges: got {cout,sum}=%h want %h", {cout, sum}, held);
    end

    // Mid-stream reset, then the same operands load on release.
    step(1'b0, 16'h4321, 16'h1234, 17'h05555, "pre_midreset");
    step(1'b1, 16'h8000, 16'h8000, 17'h00000, "midreset_assert");
    step(1'b0, 16'h8000, 16'h8000, 17'h10000, "midreset_release");

    // Random back-to-back adds; every cycle is compared so a bubble or extra
    // latency shows up as a mismatch.
    for (int i = 0; i < 10000; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      step(1'b0, ra, rb, {1'b0, ra} + {1'b0, rb}, "random");
    end

    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: got %0d leftover want 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
